chargen_sched: RTL and testbench

//  Sequences the chargen datapath: generates a cyclic ASCII stream and pushes it into the

---
 rtl/chargen_sched.sv | 155 +++++++++++++++
 tb/tb_chargen_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chargen_sched.sv
// chargen_sched: produces a cyclic ASCII stream into a FWFT char FIFO and
// drains that FIFO into a UART transmitter one byte at a time.
module chargen_sched #(
   parameter logic [7:0]  FIRST_CHAR = 8'h61,
   parameter logic [7:0]  LAST_CHAR  = 8'h7A,
   parameter bit          NEWLINE    = 1'b1,
   parameter int unsigned BURST      = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_n_full,
   output logic             fifo_n_wr,
   output logic [7:0]       fifo_in,
   input  logic             fifo_n_empty,
   output logic             fifo_n_rd,
   input  logic [7:0]       fifo_out,
   input  logic             uart_busy,
   output logic             uart_start,
   output logic [7:0]       uart_data,
   output logic [CNT_W-1:0] sent_cnt,
   output logic             done
);

   localparam int unsigned BCNT_W = $clog2(BURST + 2);
   localparam logic [7:0]  CR     = 8'h0D;
   localparam logic [7:0]  LF     = 8'h0A;

   typedef enum logic [2:0] {P_IDLE, P_CHAR, P_CR, P_LF, P_STOP} pstate_t;
   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_BUSY} cstate_t;

   pstate_t           p_state, p_next;
   cstate_t           c_state, c_next;
   logic [7:0]        ch, ch_next;
   logic [BCNT_W-1:0] wcnt, wcnt_next;
   logic              en_q;
   logic              en_rise;
   logic              wr_c;
   logic              load_c;
   logic              done_c;

   assign en_rise = en & ~en_q;

   // Producer state, current character, burst write count and enable history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state <= P_IDLE;
         ch      <= FIRST_CHAR;
         wcnt    <= '0;
         en_q    <= 1'b0;
      end else begin
         p_state <= p_next;
         ch      <= ch_next;
         wcnt    <= wcnt_next;
         en_q    <= en;
      end
   end

   // Producer next state: advance only on a committed write, restart a finished burst on en rise
   always_comb begin
      p_next    = p_state;
      ch_next   = ch;
      wcnt_next = wcnt;
      case (p_state)
         P_IDLE: begin
            if (en) p_next = P_CHAR;
         end
         P_CHAR, P_CR, P_LF: begin
            if (wr_c) begin
               case (p_state)
                  P_CHAR: begin
                     if (ch == LAST_CHAR) begin
                        ch_next = FIRST_CHAR;
                        if (NEWLINE) p_next = P_CR;
                     end else begin
                        ch_next = ch + 8'd1;
                     end
                  end
                  P_CR:    p_next = P_LF;
                  P_LF:    p_next = P_CHAR;
                  default: p_next = p_state;
               endcase
               if (BURST != 0) begin
                  wcnt_next = wcnt + BCNT_W'(1);
                  if (wcnt_next == BCNT_W'(BURST)) p_next = P_STOP;
               end
            end
         end
         P_STOP: begin
            if (en_rise) begin
               p_next    = P_CHAR;
               ch_next   = FIRST_CHAR;
               wcnt_next = '0;
            end
         end
         default: p_next = P_IDLE;
      endcase
   end

   // Producer outputs: write strobe and data follow the state directly
   always_comb begin
      wr_c = en & fifo_n_full & ((p_state == P_CHAR) | (p_state == P_CR) | (p_state == P_LF));
      fifo_n_wr = ~wr_c;
      case (p_state)
         P_CR:    fifo_in = CR;
         P_LF:    fifo_in = LF;
         default: fifo_in = ch;
      endcase
   end

   // Consumer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) c_state <= C_IDLE;
      else     c_state <= c_next;
   end

   // Consumer next state: one handoff per UART busy cycle
   always_comb begin
      c_next = c_state;
      case (c_state)
         C_IDLE:  if (load_c) c_next = C_WAIT;
         C_WAIT:  if (uart_busy) c_next = C_BUSY;
         C_BUSY:  if (!uart_busy) c_next = C_IDLE;
         default: c_next = C_IDLE;
      endcase
   end

   // Consumer decode: when to hand a byte over, and when the whole burst has drained
   always_comb begin
      load_c = (c_state == C_IDLE) & fifo_n_empty & ~uart_busy;
      done_c = (BURST != 0) & (p_state == P_STOP) & ~fifo_n_empty &
               (c_state == C_IDLE) & ~uart_busy;
   end

   // Registered UART handoff, FIFO pop pulse, byte counter and done flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uart_start <= 1'b0;
         fifo_n_rd  <= 1'b1;
         uart_data  <= 8'h00;
         sent_cnt   <= '0;
         done       <= 1'b0;
      end else begin
         uart_start <= load_c;
         fifo_n_rd  <= ~load_c;
         if (load_c) begin
            uart_data <= fifo_out;
            sent_cnt  <= sent_cnt + CNT_W'(1);
         end
         done <= done_c;
      end
   end

endmodule

// File: tb/tb_chargen_sched.sv
// Bench for chargen_sched: three instances (NEWLINE=1 endless, NEWLINE=0 endless,
// NEWLINE=1 BURST=5), each with a depth-2 FWFT FIFO model and a UART model.
module tb_chargen_sched;

   localparam int UART_LEN = 3;

   logic        clk;
   logic        rst;
   logic        en      [3];
   logic        hold    [3];
   logic        n_full  [3];
   logic        n_wr    [3];
   logic [7:0]  fin     [3];
   logic        n_empty [3];
   logic        n_rd    [3];
   logic [7:0]  fout    [3];
   logic        ubusy   [3];
   logic        ustart  [3];
   logic [7:0]  udata   [3];
   logic [15:0] cnt     [3];
   logic        done_s  [3];

   logic [7:0]  fmem    [3][2];
   int          fcnt    [3];
   int          bcnt    [3];

   int          n_chk = 0;
   int          n_pass = 0;
   int          wr_idx  [3];
   int          rd_idx  [3];
   int          txn     [3];
   logic [7:0]  txlog   [3][128];
   logic [7:0]  last_ud [3];
   bit          prev_idle [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   chargen_sched #(.NEWLINE(1'b1), .BURST(0)) u_a (
      .clk(clk), .rst(rst), .en(en[0]),
      .fifo_n_full(n_full[0]), .fifo_n_wr(n_wr[0]), .fifo_in(fin[0]),
      .fifo_n_empty(n_empty[0]), .fifo_n_rd(n_rd[0]), .fifo_out(fout[0]),
      .uart_busy(ubusy[0]), .uart_start(ustart[0]), .uart_data(udata[0]),
      .sent_cnt(cnt[0]), .done(done_s[0]));

   chargen_sched #(.NEWLINE(1'b0), .BURST(0)) u_b (
      .clk(clk), .rst(rst), .en(en[1]),
      .fifo_n_full(n_full[1]), .fifo_n_wr(n_wr[1]), .fifo_in(fin[1]),
      .fifo_n_empty(n_empty[1]), .fifo_n_rd(n_rd[1]), .fifo_out(fout[1]),
      .uart_busy(ubusy[1]), .uart_start(ustart[1]), .uart_data(udata[1]),
      .sent_cnt(cnt[1]), .done(done_s[1]));

   chargen_sched #(.NEWLINE(1'b1), .BURST(5)) u_c (
      .clk(clk), .rst(rst), .en(en[2]),
      .fifo_n_full(n_full[2]), .fifo_n_wr(n_wr[2]), .fifo_in(fin[2]),
      .fifo_n_empty(n_empty[2]), .fifo_n_rd(n_rd[2]), .fifo_out(fout[2]),
      .uart_busy(ubusy[2]), .uart_start(ustart[2]), .uart_data(udata[2]),
      .sent_cnt(cnt[2]), .done(done_s[2]));

   // FIFO flags/head and UART busy for each instance
   for (genvar g = 0; g < 3; g++) begin : g_env
      assign n_empty[g] = (fcnt[g] != 0);
      assign n_full[g]  = (fcnt[g] != 2);
      assign fout[g]    = fmem[g][0];
      assign ubusy[g]   = (bcnt[g] != 0) || hold[g];
   end

   // Depth-2 first-word-fall-through FIFO models
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            fcnt[i] <= 0;
            fmem[i][0] <= 8'h00;
            fmem[i][1] <= 8'h00;
         end else if (!n_rd[i] && fcnt[i] != 0 && !n_wr[i] && fcnt[i] != 2) begin
            fmem[i][0] <= fin[i];
         end else if (!n_rd[i] && fcnt[i] != 0) begin
            fmem[i][0] <= fmem[i][1];
            fcnt[i] <= fcnt[i] - 1;
         end else if (!n_wr[i] && fcnt[i] != 2) begin
            if (fcnt[i] == 0) fmem[i][0] <= fin[i];
            else              fmem[i][1] <= fin[i];
            fcnt[i] <= fcnt[i] + 1;
         end
      end
   end

   // UART models: busy for UART_LEN cycles after each start pulse
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst)                bcnt[i] <= 0;
         else if (ustart[i])     bcnt[i] <= UART_LEN;
         else if (bcnt[i] != 0)  bcnt[i] <= bcnt[i] - 1;
      end
   end

   // Expected n-th byte of an instance's stream since reset
   function automatic logic [7:0] exp_byte(input int inst, input int idx);
      int k;
      k = (inst == 2) ? (idx % 5) : idx;
      if (inst == 1) return 8'(32'h61 + (k % 26));
      k = k % 28;
      if (k == 26) return 8'h0D;
      if (k == 27) return 8'h0A;
      return 8'(32'h61 + k);
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, inst, act, exp, $time);
   endtask

   // kind 0: txn>=val, 1: done==val, 2: fifo_in==val
   task automatic wait_for(input int kind, input int inst, input int val, input int budget,
                           input string name);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         case (kind)
            0:       ok = (txn[inst] >= val);
            1:       ok = (done_s[inst] == (val != 0));
            default: ok = (fin[inst] == 8'(val));
         endcase
      end
      chk(name, inst, 32'(ok), 32'd1);
   endtask

   task automatic chk_reset_vals(input int i);
      chk("rst_n_wr",  i, 32'(n_wr[i]),   32'd1);
      chk("rst_n_rd",  i, 32'(n_rd[i]),   32'd1);
      chk("rst_start", i, 32'(ustart[i]), 32'd0);
      chk("rst_data",  i, 32'(udata[i]),  32'd0);
      chk("rst_cnt",   i, 32'(cnt[i]),    32'd0);
      chk("rst_done",  i, 32'(done_s[i]), 32'd0);
      chk("rst_fin",   i, 32'(fin[i]),    32'h61);
   endtask

   // Every-cycle comparison of all instances against the stream model
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 3; i++) begin
               wr_idx[i] = 0;
               rd_idx[i] = 0;
               txn[i] = 0;
               last_ud[i] = 8'h00;
               prev_idle[i] = 1'b0;
            end
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (!en[i]) chk("wr_while_disabled", i, 32'(n_wr[i]), 32'd1);
               if (!n_wr[i]) begin
                  chk("wr_while_full", i, 32'(n_full[i]), 32'd1);
                  chk("fifo_in", i, 32'(fin[i]), 32'(exp_byte(i, wr_idx[i])));
                  wr_idx[i]++;
               end
               chk("rd_vs_start", i, 32'(n_rd[i]), 32'(!ustart[i]));
               chk("sent_cnt", i, 32'(cnt[i]), 32'(16'(rd_idx[i] + (ustart[i] ? 1 : 0))));
               if (ustart[i]) begin
                  chk("pop_nonempty", i, 32'(n_empty[i]), 32'd1);
                  chk("uart_data", i, 32'(udata[i]), 32'(exp_byte(i, rd_idx[i])));
                  if (txn[i] < 128) txlog[i][txn[i]] = udata[i];
                  txn[i]++;
                  rd_idx[i]++;
               end else begin
                  chk("uart_data_hold", i, 32'(udata[i]), 32'(last_ud[i]));
               end
               last_ud[i] = udata[i];
               if (i != 2) chk("done_low", i, 32'(done_s[i]), 32'd0);
               else if (done_s[i]) chk("done_idle", i, 32'(prev_idle[i]), 32'd1);
               prev_idle[i] = !n_empty[i] && !ubusy[i] && wr_idx[i] > 0 && (wr_idx[i] % 5) == 0;
            end
         end
      end
   end

   // Directed sequence
   initial begin
      logic [7:0] held;
      int         target;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         en[i] = 1'b0;
         hold[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk_reset_vals(i);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) en[i] = 1'b1;

      // Burst of five, then restart on en 1->0->1
      wait_for(1, 2, 1, 400, "burst1_done");
      chk("burst1_len",   2, 32'(txn[2]), 32'd5);
      chk("burst1_first", 2, 32'(txlog[2][0]), 32'h61);
      chk("burst1_last",  2, 32'(txlog[2][4]), 32'h65);
      @(posedge clk);
      #1 en[2] = 1'b0;
      repeat (3) @(posedge clk);
      #1 en[2] = 1'b1;
      wait_for(0, 2, 10, 400, "burst2_bytes");
      wait_for(1, 2, 1, 400, "burst2_done");
      repeat (20) @(negedge clk);
      chk("burst2_len",   2, 32'(txn[2]), 32'd10);
      chk("burst2_first", 2, 32'(txlog[2][5]), 32'h61);
      chk("burst2_last",  2, 32'(txlog[2][9]), 32'h65);

      // Line wrap with and without CR/LF
      wait_for(0, 0, 30, 1000, "a_bytes");
      chk("a_z",    0, 32'(txlog[0][25]), 32'h7A);
      chk("a_cr",   0, 32'(txlog[0][26]), 32'h0D);
      chk("a_lf",   0, 32'(txlog[0][27]), 32'h0A);
      chk("a_wrap", 0, 32'(txlog[0][28]), 32'h61);
      wait_for(0, 1, 28, 1000, "b_bytes");
      chk("b_z",    1, 32'(txlog[1][25]), 32'h7A);
      chk("b_wrap", 1, 32'(txlog[1][26]), 32'h61);

      // Pause the producer; the FIFO drains and writing resumes in place
      @(posedge clk);
      #1 en[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("paused_drained", 0, 32'(n_empty[0]), 32'd0);
      en[0] = 1'b1;

      // Stall the UART until the FIFO fills; the pending byte must hold steady
      @(posedge clk);
      #1 hold[0] = 1'b1;
      held = 8'h00;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 5) held = fin[0];
         if (k >= 5) begin
            chk("hold_full", 0, 32'(n_full[0]), 32'd0);
            chk("hold_fin",  0, 32'(fin[0]), 32'(held));
         end
      end
      @(posedge clk);
      #1 hold[0] = 1'b0;
      target = txn[0] + 3;
      wait_for(0, 0, target, 400, "resume_after_hold");

      // Reset in the middle of a line
      wait_for(2, 0, 32'h6A, 600, "reach_6a");
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk_reset_vals(0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_for(0, 0, 1, 200, "first_after_rst");
      chk("restart_byte", 0, 32'(txlog[0][0]), 32'h61);
      chk("restart_cnt",  0, 32'(cnt[0]), 32'd1);
      repeat (40) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
